exception_controller: RTL and testbench

EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

---
 rtl/exception_controller_pkg.sv | 19 +
 rtl/exception_controller_prio_enc.sv | 29 ++
 rtl/exception_controller.sv | 127 ++++++++++++
 tb/tb_exception_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_controller_pkg.sv
// Shared types and constants for the exception controller.
package exception_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_VECTOR,
        ST_HANDLER,
        ST_RETURN
    } state_e;

    localparam logic [1:0] EXC_SYSCALL  = 2'd0;
    localparam logic [1:0] EXC_INVALID  = 2'd1;
    localparam logic [1:0] EXC_OVERFLOW = 2'd2;
    localparam logic [1:0] EXC_EXTINT   = 2'd3;

    localparam logic [31:0] VECTOR_BASE_DEF = 32'h0000_0180;

endpackage

// File: rtl/exception_controller_prio_enc.sv
// Fixed-priority encoder: syscall > invalid > overflow > interrupt.
module exc_prio_enc
    import exception_controller_pkg::*;
(
    input  logic       i_syscall,
    input  logic       i_invalid,
    input  logic       i_overflow,
    input  logic       i_irq,
    output logic [1:0] o_id,
    output logic       o_valid
);

    always_comb begin
        o_id    = EXC_SYSCALL;
        o_valid = 1'b1;
        if (i_syscall) begin
            o_id = EXC_SYSCALL;
        end else if (i_invalid) begin
            o_id = EXC_INVALID;
        end else if (i_overflow) begin
            o_id = EXC_OVERFLOW;
        end else if (i_irq) begin
            o_id = EXC_EXTINT;
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/exception_controller.sv
// Exception sequencer: flush, vector, handler, return, with pending interrupt.
module exception_controller
    import exception_controller_pkg::*;
#(
    parameter logic [31:0] VECTOR_BASE  = VECTOR_BASE_DEF,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall,
    input  logic        invalid,
    input  logic        overflow,
    input  logic        ext_int,
    input  logic [31:0] pc_in,
    input  logic        eret,
    output logic        stall,
    output logic        flush,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic [1:0]  cause,
    output logic [31:0] epc,
    output logic        in_handler,
    output logic        double_fault
);

    localparam logic [2:0] LAST_CNT = 3'(FLUSH_CYCLES - 1);

    state_e      r_state;
    state_e      w_next;
    logic [2:0]  r_cnt;
    logic        r_pend;
    logic [1:0]  r_cause;
    logic [31:0] r_epc;
    logic        r_dfault;
    logic        w_sync;
    logic        w_irq;
    logic [1:0]  w_id;
    logic        w_valid;

    assign w_sync = syscall | invalid | overflow;
    assign w_irq  = ext_int | r_pend;

    exc_prio_enc u_prio (
        .i_syscall  (syscall),
        .i_invalid  (invalid),
        .i_overflow (overflow),
        .i_irq      (w_irq),
        .o_id       (w_id),
        .o_valid    (w_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_valid) w_next = ST_FLUSH;
            ST_FLUSH:   if (r_cnt == LAST_CNT) w_next = ST_VECTOR;
            ST_VECTOR:  w_next = ST_HANDLER;
            ST_HANDLER: if (eret) w_next = ST_RETURN;
            ST_RETURN:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= 3'd0;
            r_pend   <= 1'b0;
            r_cause  <= 2'd0;
            r_epc    <= 32'd0;
            r_dfault <= 1'b0;
        end else begin
            r_cnt <= (r_state == ST_FLUSH) ? r_cnt + 3'd1 : 3'd0;
            if (r_state == ST_IDLE && w_valid) begin
                r_cause <= w_id;
                r_epc   <= pc_in;
            end
            // A losing ext_int in IDLE is kept, not dropped.
            if (r_state == ST_IDLE && w_valid && w_id == EXC_EXTINT) begin
                r_pend <= 1'b0;
            end else if (ext_int) begin
                r_pend <= 1'b1;
            end
            if (r_state == ST_HANDLER && w_sync) begin
                r_dfault <= 1'b1;
            end
        end
    end

    always_comb begin
        stall      = 1'b0;
        flush      = 1'b0;
        pc_load    = 1'b0;
        in_handler = 1'b0;
        pc_target  = 32'd0;
        unique case (r_state)
            ST_FLUSH: begin
                stall = 1'b1;
                flush = 1'b1;
            end
            ST_VECTOR: begin
                stall     = 1'b1;
                pc_load   = 1'b1;
                pc_target = VECTOR_BASE + {26'd0, r_cause, 4'd0};
            end
            ST_HANDLER: in_handler = 1'b1;
            ST_RETURN: begin
                stall     = 1'b1;
                pc_load   = 1'b1;
                pc_target = r_epc;
            end
            default: ;
        endcase
    end

    assign cause        = r_cause;
    assign epc          = r_epc;
    assign double_fault = r_dfault;

endmodule

// File: tb/tb_exception_controller.sv
// Randomized scoreboard bench for exception_controller.
module tb_exception_controller;

    localparam logic [31:0] BASE = 32'h0000_0180;
    localparam int          FC   = 2;

    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_SEQ  = 2'd1;
    localparam logic [1:0] K_HDL  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic        stall;
        logic        flush;
        logic        pcl;
        logic        inh;
        logic [31:0] tgt;
    } ent_t;

    typedef struct packed {
        ent_t        o;
        logic [1:0]  cause;
        logic [31:0] epc;
        logic        df;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        syscall;
    logic        invalid;
    logic        overflow;
    logic        ext_int;
    logic [31:0] pc_in;
    logic        eret;
    logic        stall;
    logic        flush;
    logic        pc_load;
    logic [31:0] pc_target;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic        in_handler;
    logic        double_fault;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    ent_t       m_cur;
    ent_t       m_q[$];
    logic [1:0] m_cause;
    logic [31:0] m_epc;
    logic       m_pend;
    logic       m_df;

    exception_controller #(
        .VECTOR_BASE  (BASE),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .syscall      (syscall),
        .invalid      (invalid),
        .overflow     (overflow),
        .ext_int      (ext_int),
        .pc_in        (pc_in),
        .eret         (eret),
        .stall        (stall),
        .flush        (flush),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .cause        (cause),
        .epc          (epc),
        .in_handler   (in_handler),
        .double_fault (double_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, a, x, $time);
        end
    endtask

    function automatic ent_t mk(input logic [1:0] k, input logic st,
                                input logic fl, input logic pl,
                                input logic ih, input logic [31:0] t);
        ent_t e;
        e.kind  = k;
        e.stall = st;
        e.flush = fl;
        e.pcl   = pl;
        e.inh   = ih;
        e.tgt   = t;
        return e;
    endfunction

    task automatic model_reset();
        m_cur   = mk(K_IDLE, 0, 0, 0, 0, 32'd0);
        m_q.delete();
        m_cause = 2'd0;
        m_epc   = 32'd0;
        m_pend  = 1'b0;
        m_df    = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_flush"}, 32'(flush), 0);
        chk({tag, "_pc_load"}, 32'(pc_load), 0);
        chk({tag, "_pc_target"}, pc_target, 0);
        chk({tag, "_cause"}, 32'(cause), 0);
        chk({tag, "_epc"}, epc, 0);
        chk({tag, "_in_handler"}, 32'(in_handler), 0);
        chk({tag, "_double_fault"}, 32'(double_fault), 0);
    endtask

    // One cycle: drive inputs, advance the sequence model, queue expectation.
    task automatic step(input logic sc, input logic iv, input logic ov,
                        input logic ei, input logic er,
                        input logic [31:0] pc);
        exp_t       x;
        logic [1:0] c;
        @(negedge clk);
        syscall  = sc;
        invalid  = iv;
        overflow = ov;
        ext_int  = ei;
        eret     = er;
        pc_in    = pc;
        if (m_cur.kind == K_IDLE) begin
            if (sc || iv || ov || ei || m_pend) begin
                c = sc ? 2'd0 : iv ? 2'd1 : ov ? 2'd2 : 2'd3;
                m_cause = c;
                m_epc   = pc;
                if (c == 2'd3) m_pend = 1'b0;
                else if (ei) m_pend = 1'b1;
                for (int i = 0; i < FC; i++)
                    m_q.push_back(mk(K_SEQ, 1, 1, 0, 0, 32'd0));
                m_q.push_back(mk(K_SEQ, 1, 0, 1, 0, BASE + 32'(c) * 16));
                m_q.push_back(mk(K_HDL, 0, 0, 0, 1, 32'd0));
            end
        end else if (m_cur.kind == K_SEQ) begin
            if (ei) m_pend = 1'b1;
        end else begin
            if (ei) m_pend = 1'b1;
            if (sc || iv || ov) m_df = 1'b1;
            if (er) begin
                m_q.push_back(mk(K_SEQ, 1, 0, 1, 0, m_epc));
                m_q.push_back(mk(K_IDLE, 0, 0, 0, 0, 32'd0));
            end
        end
        if (m_q.size() > 0) m_cur = m_q.pop_front();
        x.o     = m_cur;
        x.cause = m_cause;
        x.epc   = m_epc;
        x.df    = m_df;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, $urandom);
    endtask

    // Asynchronous reset in the middle of a cycle, released mid-cycle later.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_zero(tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.o.stall));
            chk("flush", 32'(flush), 32'(e.o.flush));
            chk("pc_load", 32'(pc_load), 32'(e.o.pcl));
            chk("pc_target", pc_target, e.o.tgt);
            chk("in_handler", 32'(in_handler), 32'(e.o.inh));
            chk("cause", 32'(cause), 32'(e.cause));
            chk("epc", epc, e.epc);
            chk("double_fault", 32'(double_fault), 32'(e.df));
        end
    end

    initial begin
        rst      = 1'b0;
        syscall  = 1'b0;
        invalid  = 1'b0;
        overflow = 1'b0;
        ext_int  = 1'b0;
        eret     = 1'b0;
        pc_in    = 32'd0;
        model_reset();
        #1;
        check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;

        step(0, 0, 1, 0, 0, 32'h0040_0010);
        idle(5);
        step(0, 0, 0, 0, 1, $urandom);
        idle(3);

        step(1, 1, 0, 1, 0, 32'h0000_1000);
        idle(5);
        step(0, 0, 0, 0, 1, $urandom);
        idle(8);
        step(0, 0, 0, 0, 1, $urandom);
        idle(3);

        step(0, 0, 1, 0, 0, 32'h0000_2000);
        idle(5);
        step(0, 0, 0, 1, 0, $urandom);
        idle(2);
        step(0, 0, 0, 0, 1, $urandom);
        idle(8);
        step(0, 0, 0, 0, 1, $urandom);
        idle(3);

        step(1, 0, 0, 0, 0, 32'h0000_3000);
        idle(5);
        step(0, 1, 0, 0, 0, 32'h0000_3abc);
        idle(2);
        step(0, 0, 0, 0, 1, $urandom);
        idle(3);
        step(0, 0, 0, 0, 1, $urandom);
        idle(2);

        mid_reset("dfault_reset");
        step(0, 0, 0, 0, 1, 32'h0000_4000);
        idle(2);

        step(0, 0, 1, 0, 0, 32'h0000_5000);
        step(0, 0, 0, 0, 0, 32'h0);
        mid_reset("flush_reset");
        step(0, 0, 1, 0, 0, 32'h0000_6000);
        idle(5);
        step(0, 0, 0, 0, 1, $urandom);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0, $urandom);
            if (i % 700 == 350) mid_reset("rand_reset");
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
